// File: rtl/bcd_tick_counter.sv
// Multi-digit packed-BCD up/down counter advanced by an internal prescaler.
// Synchronous clear/load, wrap-or-saturate limits, and step/wrap strobes.
module bcd_tick_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  step,
  output logic                  wrap,
  output logic                  at_limit
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  clamp_val;
  logic          all9;
  logic          all0;

  assign tick     = en && (presc == PMAX);
  assign at_limit = up ? all9 : all0;

  // Ripple carry/borrow across digits; all-9 increments to all-0 and
  // all-0 decrements to all-9, so the wrap result falls out naturally.
  always_comb begin
    logic       c;
    logic       b;
    logic [3:0] d;
    logic [3:0] lv;
    inc_val   = '0;
    dec_val   = '0;
    clamp_val = '0;
    all9      = 1'b1;
    all0      = 1'b1;
    c         = 1'b1;
    b         = 1'b1;
    d         = '0;
    lv        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d    = digits[4*i +: 4];
      all9 = all9 & (d == 4'd9);
      all0 = all0 & (d == 4'd0);
      if (c) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = d;
      end
      if (b) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = d;
      end
      lv = load_val[4*i +: 4];
      clamp_val[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      presc  <= '0;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (clr) begin
        digits <= '0;
        presc  <= '0;
      end else if (load) begin
        digits <= clamp_val;
        presc  <= '0;
      end else if (en) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (up) begin
            if (!(all9 && sat)) begin
              digits <= inc_val;
              step   <= 1'b1;
              wrap   <= all9;
            end
          end else begin
            if (!(all0 && sat)) begin
              digits <= dec_val;
              step   <= 1'b1;
              wrap   <= all0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: four instances of different widths/prescales
// checked each cycle against an integer-valued model plus directed literals.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        sat = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_val = '0;

  logic [7:0]  dig_a, dig_b;
  logic [3:0]  dig_c;
  logic [31:0] dig_d;
  logic        step_a, step_b, step_c, step_d;
  logic        wrap_a, wrap_b, wrap_c, wrap_d;
  logic        lim_a, lim_b, lim_c, lim_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_tick_counter #(.DIGITS(2), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .digits(dig_a), .step(step_a), .wrap(wrap_a), .at_limit(lim_a));
  bcd_tick_counter #(.DIGITS(2), .PRESCALE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .digits(dig_b), .step(step_b), .wrap(wrap_b), .at_limit(lim_b));
  bcd_tick_counter #(.DIGITS(1), .PRESCALE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .digits(dig_c), .step(step_c), .wrap(wrap_c), .at_limit(lim_c));
  bcd_tick_counter #(.DIGITS(8), .PRESCALE(1)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .digits(dig_d), .step(step_d), .wrap(wrap_d), .at_limit(lim_d));

  logic [31:0] got_dig[4];
  logic        got_step[4], got_wrap[4], got_lim[4];
  assign got_dig[0] = {24'd0, dig_a};
  assign got_dig[1] = {24'd0, dig_b};
  assign got_dig[2] = {28'd0, dig_c};
  assign got_dig[3] = dig_d;
  assign got_step[0] = step_a; assign got_step[1] = step_b;
  assign got_step[2] = step_c; assign got_step[3] = step_d;
  assign got_wrap[0] = wrap_a; assign got_wrap[1] = wrap_b;
  assign got_wrap[2] = wrap_c; assign got_wrap[3] = wrap_d;
  assign got_lim[0] = lim_a; assign got_lim[1] = lim_b;
  assign got_lim[2] = lim_c; assign got_lim[3] = lim_d;

  // Model: counter value as a plain integer, prescale phase as an edge count.
  int     nd[4] = '{2, 2, 1, 8};
  int     ps[4] = '{1, 4, 1, 1};
  longint m_val[4];
  int     m_cnt[4];
  bit     m_step[4];
  bit     m_wrap[4];

  function automatic longint p10(int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(longint v, int n);
    logic [31:0] r = '0;
    longint t = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint from_load(logic [31:0] lv, int n);
    longint r = 0;
    logic [3:0] nb;
    for (int i = 0; i < n; i++) begin
      nb = lv[4*i +: 4];
      if (nb > 4'd9) nb = 4'd9;
      r = r + longint'(nb) * p10(i);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      longint maxv;
      maxv = p10(nd[k]) - 1;
      m_step[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (!rst_n) begin
        m_val[k] = 0;
        m_cnt[k] = 0;
      end else if (clr) begin
        m_val[k] = 0;
        m_cnt[k] = 0;
      end else if (load) begin
        m_val[k] = from_load(load_val, nd[k]);
        m_cnt[k] = 0;
      end else if (en) begin
        if (m_cnt[k] == ps[k] - 1) begin
          m_cnt[k] = 0;
          if (up) begin
            if (m_val[k] < maxv) begin
              m_val[k] = m_val[k] + 1; m_step[k] = 1'b1;
            end else if (!sat) begin
              m_val[k] = 0; m_step[k] = 1'b1; m_wrap[k] = 1'b1;
            end
          end else begin
            if (m_val[k] > 0) begin
              m_val[k] = m_val[k] - 1; m_step[k] = 1'b1;
            end else if (!sat) begin
              m_val[k] = maxv; m_step[k] = 1'b1; m_wrap[k] = 1'b1;
            end
          end
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      bit lim;
      lim = up ? (m_val[k] == p10(nd[k]) - 1) : (m_val[k] == 0);
      chk($sformatf("model_digits%0d", k), got_dig[k], to_bcd(m_val[k], nd[k]));
      chk($sformatf("model_step%0d", k), 32'(got_step[k]), 32'(m_step[k]));
      chk($sformatf("model_wrap%0d", k), 32'(got_wrap[k]), 32'(m_wrap[k]));
      chk($sformatf("model_at_limit%0d", k), 32'(got_lim[k]), 32'(lim));
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_load(logic [31:0] v);
    load_val = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("reset_digits_d", dig_d, 32'h0);
    chk("reset_step_a", 32'(step_a), 32'd0);
    rst_n = 1'b1;

    // Up count and wrap, 2 digits, every edge a tick
    clr = 1'b1; cyc(1); clr = 1'b0;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    cyc(10); chk("up_10_edges", 32'(dig_a), 32'h10);
    cyc(89); chk("up_99_edges", 32'(dig_a), 32'h99);
    chk("up_99_at_limit", 32'(lim_a), 32'd1);
    cyc(1); chk("up_wrap_digits", 32'(dig_a), 32'h00);
    chk("up_wrap_wrap", 32'(wrap_a), 32'd1);
    chk("up_wrap_step", 32'(step_a), 32'd1);
    cyc(1); chk("after_wrap_wrap", 32'(wrap_a), 32'd0);
    chk("after_wrap_digits", 32'(dig_a), 32'h01);

    // Asynchronous reset between edges
    clr = 1'b1; cyc(1); clr = 1'b0;
    cyc(37); chk("count_37", 32'(dig_a), 32'h37);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(dig_a), 32'h00);
    chk("async_rst_step", 32'(step_a), 32'd0);
    chk("async_rst_wrap", 32'(wrap_a), 32'd0);
    cyc(1); rst_n = 1'b1;

    // Prescale 4 with an enable gap
    en = 1'b0; clr = 1'b1; cyc(1); clr = 1'b0; en = 1'b1;
    cyc(3); chk("ps_edge3", 32'(dig_b), 32'h00);
    cyc(1); chk("ps_edge4", 32'(dig_b), 32'h01);
    cyc(2); en = 1'b0; cyc(3); en = 1'b1;
    cyc(1); chk("ps_edge10", 32'(dig_b), 32'h01);
    cyc(1); chk("ps_edge11", 32'(dig_b), 32'h02);

    // Down boundaries
    up = 1'b0; sat = 1'b0;
    pulse_load(32'h10); cyc(1); chk("down_10_to_09", 32'(dig_a), 32'h09);
    pulse_load(32'h00); cyc(1); chk("down_wrap_digits", 32'(dig_a), 32'h99);
    chk("down_wrap_wrap", 32'(wrap_a), 32'd1);
    sat = 1'b1;
    pulse_load(32'h00); cyc(1); chk("down_sat_digits", 32'(dig_a), 32'h00);
    chk("down_sat_step", 32'(step_a), 32'd0);
    chk("down_sat_wrap", 32'(wrap_a), 32'd0);
    chk("down_sat_limit", 32'(lim_a), 32'd1);

    // Load clamp and priority
    pulse_load(32'h3A); chk("load_clamp", 32'(dig_a), 32'h39);
    clr = 1'b1; load = 1'b1; load_val = 32'h55; cyc(1);
    clr = 1'b0; load = 1'b0; chk("clr_over_load", 32'(dig_a), 32'h00);
    up = 1'b1; sat = 1'b0;
    clr = 1'b1; cyc(1); clr = 1'b0;
    cyc(3); pulse_load(32'h25);
    chk("load_on_tick_digits", 32'(dig_b), 32'h25);
    chk("load_on_tick_step", 32'(step_b), 32'd0);
    cyc(3); chk("load_then_3", 32'(dig_b), 32'h25);
    cyc(1); chk("load_then_4", 32'(dig_b), 32'h26);

    // Width sweep
    pulse_load(32'h99999999);
    chk("d1_loaded", 32'(dig_c), 32'h9);
    chk("d8_loaded", dig_d, 32'h99999999);
    cyc(1);
    chk("d1_wrap_digits", 32'(dig_c), 32'h0);
    chk("d1_wrap_wrap", 32'(wrap_c), 32'd1);
    chk("d8_wrap_digits", dig_d, 32'h00000000);
    chk("d8_wrap_wrap", 32'(wrap_d), 32'd1);

    // Randomized traffic checked by the per-cycle model
    repeat (3000) begin
      rst_n = ($urandom_range(0, 300) != 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = $urandom_range(0, 1) == 1;
      sat   = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 60) == 0);
      load  = ($urandom_range(0, 25) == 0);
      case ($urandom_range(0, 3))
        0: load_val = 32'h99999999;
        1: load_val = 32'h0;
        default: load_val = $urandom;
      endcase
      cyc(1);
    end
    rst_n = 1'b1; clr = 1'b0; load = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised multi-digit BCD up/down counter with a built-in prescaler, synchronous load/clear and a wrap-or-saturate mode. It is the next generation of the free-running 8-bit display counter. It produces packed BCD digits ready for the TM1638 segment encoder/shift path, plus step and wrap strobes for chaining or LED indication.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits (1..8); value width is 4*DIGITS.
- PRESCALE, 50000000, enabled clock edges per count step (>=1); prescaler width = clog2(PRESCALE), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; gates the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on the step edge.
- sat  in  1  mode: 1 = saturate at limits, 0 = wrap.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
- digits  out  4*DIGITS  registered packed BCD count value.
- step  out  1  registered 1-cycle pulse on each edge where the value changes because of a tick.
- wrap  out  1  registered 1-cycle pulse on each edge where the value wraps (99..9->0 or 0->99..9).
- at_limit  out  1  combinational: digits all 9 when up=1, or all 0 when up=0.

## Operation
- Reset (rst_n low, any time, asynchronous): digits=0, prescaler=0, step=0, wrap=0. Any in-progress prescale period is discarded.
- Priority per edge: clr > load > tick > hold.
- clr: digits=0 and prescaler=0. No step or wrap pulse.
- load: digits=load_val with each nibble >9 clamped to 9. Prescaler=0. No step or wrap pulse.
- Prescaler:
  - Only advances while en=1; holds its value while en=0.
  - A tick occurs on an enabled edge when prescaler==PRESCALE-1; the prescaler returns to 0 on that edge.
  - With PRESCALE=1, every enabled edge is a tick.
- Up-tick:
  - BCD ripple increment: digit i goes 9->0 and carries into digit i+1; otherwise digit i+1.
  - At all-9 with sat=0: result is all 0, wrap=1, step=1.
  - At all-9 with sat=1: value holds, step=0, wrap=0.
- Down-tick:
  - BCD ripple decrement with borrow: digit i goes 0->9 and borrows from digit i+1.
  - At all-0 with sat=0: result is all 9, wrap=1, step=1.
  - At all-0 with sat=1: value holds, step=0, wrap=0.
- step and wrap are 0 on every edge that is not an effective tick.
- Digits are always valid BCD (0..9). Invalid values can only arise from load_val, and those are clamped.
- sat and up may change at any time. Only their values at the tick edge matter.

## Timing
- From reset release with en held at 1, the first value change is on the PRESCALE-th rising edge. Subsequent changes occur every PRESCALE enabled edges.
- Deasserting en pauses the period. Reasserting it resumes the period without losing phase.
- digits, step and wrap update on the same edge. step/wrap are high for exactly one cycle following that edge.
- load/clr take effect on the edge where they are sampled high. A tick that coincides with load or clr is dropped.
- at_limit has zero latency from digits and up (combinational).

## Test plan
- Reset mid-count: DIGITS=2, PRESCALE=1, count to 8'h37, pull rst_n low between edges -> digits=8'h00, step=0, wrap=0 immediately, without waiting for a clock edge.
- Up wrap: DIGITS=2, PRESCALE=1, sat=0, up=1, en=1 from 0:
  - after 10 edges digits=8'h10;
  - after 99 edges 8'h99 with at_limit=1;
  - edge 100 gives 8'h00 with wrap=1 and step=1 for one cycle.
- Prescale and enable: PRESCALE=4, en=1 -> changes on edges 4, 8, 12. Dropping en for 3 cycles after edge 6 delays the next change to edge 11.
- Down boundaries: DIGITS=2, PRESCALE=1, up=0:
  - from 8'h10 one tick gives 8'h09;
  - from 8'h00 with sat=0 gives 8'h99 with wrap=1;
  - from 8'h00 with sat=1 value stays 8'h00, step=0, wrap=0, at_limit=1.
- Load/clear priority: load_val=8'h3A gives digits=8'h39. load and clr both high gives 8'h00. load on a tick edge gives the loaded value, step=0, and the next tick PRESCALE edges later.
- Width sweep: DIGITS=1 and DIGITS=8, up=1, sat=0 -> 9->0 wrap for DIGITS=1; 32'h99999999->32'h00000000 with wrap=1 for DIGITS=8.
